// File: rtl/countdown_sequencer_if.sv
// Signal bundle between the countdown sequencer, its controller and the overlay renderer.
interface countdown_sequencer_if;
  logic       start;
  logic       abort;
  logic       frame_tick;
  logic [1:0] cd_value;
  logic       cd_active;
  logic       step_pulse;
  logic       done;
  logic       busy;

  modport master (
    output start, abort, frame_tick,
    input  cd_value, cd_active, step_pulse, done, busy
  );

  modport slave (
    input  start, abort, frame_tick,
    output cd_value, cd_active, step_pulse, done, busy
  );
endinterface

// File: rtl/countdown_sequencer.sv
// Frame-synchronous 3-2-1-GO sequencer; digits only change on frame_tick so the
// overlay never updates mid-frame.
module countdown_sequencer #(
  parameter int unsigned FRAMES_PER_STEP = 60,
  parameter int unsigned GO_FRAMES       = 60
) (
  input  logic                          clk,
  input  logic                          rst_n,
  countdown_sequencer_if.slave          cd
);

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned CD_W      = 2;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0] GO_LAST   = CNT_W'(GO_FRAMES - 1);
  localparam logic [CD_W-1:0]  CD_FIRST  = CD_W'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_COUNT,
    S_GO
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CD_W-1:0]  r_cd_value;
  logic             r_cd_active;
  logic             r_step_pulse;
  logic             r_done;
  logic             r_busy;

  state_t           w_state;
  logic [CNT_W-1:0] w_frame_cnt;
  logic [CD_W-1:0]  w_cd_value;
  logic             w_cd_active;
  logic             w_step_pulse;
  logic             w_done;
  logic             w_busy;

  // State register; all outputs are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_frame_cnt  <= '0;
      r_cd_value   <= CD_FIRST;
      r_cd_active  <= 1'b0;
      r_step_pulse <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_frame_cnt  <= w_frame_cnt;
      r_cd_value   <= w_cd_value;
      r_cd_active  <= w_cd_active;
      r_step_pulse <= w_step_pulse;
      r_done       <= w_done;
      r_busy       <= w_busy;
    end
  end

  // Next state; abort beats frame_tick, which beats start.
  always_comb begin
    w_state      = r_state;
    w_frame_cnt  = r_frame_cnt;
    w_cd_value   = r_cd_value;
    w_step_pulse = 1'b0;
    w_done       = 1'b0;

    if (cd.abort) begin
      w_state     = S_IDLE;
      w_frame_cnt = '0;
      w_cd_value  = CD_FIRST;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_frame_cnt = '0;
          w_cd_value  = CD_FIRST;
          if (cd.start) w_state = S_ARM;
        end
        S_ARM: begin
          if (cd.frame_tick) begin
            w_state     = S_COUNT;
            w_frame_cnt = '0;
            w_cd_value  = CD_FIRST;
          end
        end
        S_COUNT: begin
          if (cd.frame_tick) begin
            if (r_frame_cnt == STEP_LAST) begin
              w_frame_cnt  = '0;
              w_cd_value   = r_cd_value - CD_W'(1);
              w_step_pulse = 1'b1;
              if (r_cd_value == CD_W'(1)) w_state = S_GO;
            end else begin
              w_frame_cnt = r_frame_cnt + CNT_W'(1);
            end
          end
        end
        S_GO: begin
          if (cd.frame_tick) begin
            if (r_frame_cnt == GO_LAST) begin
              w_state     = S_IDLE;
              w_frame_cnt = '0;
              w_cd_value  = CD_FIRST;
              w_done      = 1'b1;
            end else begin
              w_frame_cnt = r_frame_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          w_state     = S_IDLE;
          w_frame_cnt = '0;
          w_cd_value  = CD_FIRST;
        end
      endcase
    end

    w_busy      = (w_state != S_IDLE);
    w_cd_active = (w_state == S_COUNT) || (w_state == S_GO);
  end

  assign cd.cd_value   = r_cd_value;
  assign cd.cd_active  = r_cd_active;
  assign cd.step_pulse = r_step_pulse;
  assign cd.done       = r_done;
  assign cd.busy       = r_busy;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: directed vector table, held-start sequence and
// randomized traffic checked against a tick-count reference model.
module tb_countdown_sequencer;

  localparam int F = 2;
  localparam int G = 3;

  logic clk;
  logic rst_n;

  countdown_sequencer_if u_if ();

  countdown_sequencer #(
    .FRAMES_PER_STEP(F),
    .GO_FRAMES      (G)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cd   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       rn;
    logic       st;
    logic       ab;
    logic       tk;
    logic [1:0] cd;
    logic       act;
    logic       stp;
    logic       dn;
    logic       bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0d, want %0d", name, idx, got, want);
    end
  endtask

  task automatic drive(input logic rn, input logic s, input logic a, input logic t);
    @(negedge clk);
    rst_n            = rn;
    u_if.start       = s;
    u_if.abort       = a;
    u_if.frame_tick  = t;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [1:0] cd,
                         input logic act, input logic stp, input logic dn, input logic bsy);
    chk({tag, ".cd_value"},   idx, int'(u_if.cd_value),   int'(cd));
    chk({tag, ".cd_active"},  idx, int'(u_if.cd_active),  int'(act));
    chk({tag, ".step_pulse"}, idx, int'(u_if.step_pulse), int'(stp));
    chk({tag, ".done"},       idx, int'(u_if.done),       int'(dn));
    chk({tag, ".busy"},       idx, int'(u_if.busy),       int'(bsy));
  endtask

  function automatic vec_t v(input logic rn, input logic st, input logic ab, input logic tk,
                             input logic [1:0] cd, input logic act, input logic stp,
                             input logic dn, input logic bsy);
    vec_t r;
    r.rn = rn; r.st = st; r.ab = ab; r.tk = tk;
    r.cd = cd; r.act = act; r.stp = stp; r.dn = dn; r.bsy = bsy;
    return r;
  endfunction

  // Reference model: a run is "ticks seen since entry"; digit and pulses follow arithmetically.
  int m_mode;  // 0 idle, 1 waiting for first tick, 2 running
  int m_n;
  logic [1:0] e_cd;
  logic e_act, e_stp, e_dn, e_bsy;

  task automatic model_step(input logic rn, input logic s, input logic a, input logic t);
    e_stp = 1'b0;
    e_dn  = 1'b0;
    if (!rn || a) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (s) m_mode = 1;
    end else if (m_mode == 1) begin
      if (t) begin
        m_mode = 2;
        m_n    = 0;
      end
    end else if (t) begin
      m_n++;
      if (m_n == 3*F + G) begin
        m_mode = 0;
        e_dn   = 1'b1;
      end else if (m_n % F == 0 && m_n <= 3*F) begin
        e_stp = 1'b1;
      end
    end
    e_act = (m_mode == 2);
    e_bsy = (m_mode != 0);
    if (m_mode == 2) e_cd = (m_n >= 3*F) ? 2'd0 : 2'(3 - m_n / F);
    else             e_cd = 2'd3;
  endtask

  initial begin
    rst_n           = 1'b0;
    u_if.start      = 1'b0;
    u_if.abort      = 1'b0;
    u_if.frame_tick = 1'b0;

    // Reset state
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("reset", 0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // start+tick together in IDLE, normal run with re-triggers, done after GO
    vecs.push_back(v(1,1,0,1, 3,0,0,0,1));
    vecs.push_back(v(1,0,0,1, 3,1,0,0,1));
    vecs.push_back(v(1,0,0,0, 3,1,0,0,1));
    vecs.push_back(v(1,0,0,1, 3,1,0,0,1));
    vecs.push_back(v(1,1,0,1, 2,1,1,0,1));
    vecs.push_back(v(1,0,0,1, 2,1,0,0,1));
    vecs.push_back(v(1,0,0,1, 1,1,1,0,1));
    vecs.push_back(v(1,1,0,0, 1,1,0,0,1));
    vecs.push_back(v(1,0,0,1, 1,1,0,0,1));
    vecs.push_back(v(1,0,0,1, 0,1,1,0,1));
    vecs.push_back(v(1,1,0,1, 0,1,0,0,1));
    vecs.push_back(v(1,0,0,1, 0,1,0,0,1));
    vecs.push_back(v(1,0,0,1, 3,0,0,1,0));
    vecs.push_back(v(1,0,0,0, 3,0,0,0,0));
    // abort in COUNT while showing 2, colliding with a tick
    vecs.push_back(v(1,1,0,0, 3,0,0,0,1));
    vecs.push_back(v(1,0,0,1, 3,1,0,0,1));
    vecs.push_back(v(1,0,0,1, 3,1,0,0,1));
    vecs.push_back(v(1,0,0,1, 2,1,1,0,1));
    vecs.push_back(v(1,0,0,1, 2,1,0,0,1));
    vecs.push_back(v(1,0,1,1, 3,0,0,0,0));
    vecs.push_back(v(1,0,0,1, 3,0,0,0,0));
    vecs.push_back(v(1,0,0,1, 3,0,0,0,0));
    // synchronous reset while in GO, then a fresh start
    vecs.push_back(v(1,1,0,0, 3,0,0,0,1));
    vecs.push_back(v(1,0,0,1, 3,1,0,0,1));
    vecs.push_back(v(1,0,0,1, 3,1,0,0,1));
    vecs.push_back(v(1,0,0,1, 2,1,1,0,1));
    vecs.push_back(v(1,0,0,1, 2,1,0,0,1));
    vecs.push_back(v(1,0,0,1, 1,1,1,0,1));
    vecs.push_back(v(1,0,0,1, 1,1,0,0,1));
    vecs.push_back(v(1,0,0,1, 0,1,1,0,1));
    vecs.push_back(v(0,0,0,1, 3,0,0,0,0));
    vecs.push_back(v(1,1,0,0, 3,0,0,0,1));
    vecs.push_back(v(1,0,0,1, 3,1,0,0,1));
    vecs.push_back(v(1,0,1,0, 3,0,0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rn, vecs[i].st, vecs[i].ab, vecs[i].tk);
      chk_all("vec", i, vecs[i].cd, vecs[i].act, vecs[i].stp, vecs[i].dn, vecs[i].bsy);
    end

    // start held high with a tick every cycle: back-to-back runs
    begin
      int seen;
      seen = 0;
      for (int c = 1; c <= 40 && seen == 0; c++) begin
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        if (u_if.done) seen = c;
      end
      chk("held.first_done_cycle", 0, seen, 11);
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      chk_all("held.rearm", 1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      chk_all("held.entry", 2, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
      seen = 0;
      for (int c = 1; c <= 40 && seen == 0; c++) begin
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        if (u_if.done) seen = c;
      end
      chk("held.second_done_cycle", 3, seen, 3*F + G);
    end

    // Randomized traffic against the reference model
    m_mode = 0;
    m_n    = 0;
    for (int i = 0; i < 3000; i++) begin
      logic rn, s, a, t;
      rn = (i == 0) ? 1'b0 : ($urandom_range(0, 127) != 0);
      s  = ($urandom_range(0, 7) == 0);
      a  = ($urandom_range(0, 63) == 0);
      t  = ($urandom_range(0, 1) == 0);
      drive(rn, s, a, t);
      model_step(rn, s, a, t);
      chk_all("rand", i, e_cd, e_act, e_stp, e_dn, e_bsy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
